// File: rtl/tfe_flow_state_table_if.sv
// Lookup request, per-flow response and table-clear handshake of the TFE flow state table.
interface tfe_flow_state_table_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned TIME_W = 34
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TIME_W-1:0] req_time;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [CNT_W-1:0]  rsp_pkt_cnt;
  logic              rsp_new;
  logic              rsp_expired;
  logic [CNT_W-1:0]  rsp_old_cnt;
  logic [TIME_W-1:0] rsp_old_time;
  logic              clear_start;
  logic              clear_busy;

  modport master (
    output req_valid, req_addr, req_time, clear_start,
    input  req_ready, rsp_valid, rsp_addr, rsp_pkt_cnt, rsp_new, rsp_expired,
           rsp_old_cnt, rsp_old_time, clear_busy
  );

  modport slave (
    input  req_valid, req_addr, req_time, clear_start,
    output req_ready, rsp_valid, rsp_addr, rsp_pkt_cnt, rsp_new, rsp_expired,
           rsp_old_cnt, rsp_old_time, clear_busy
  );
endinterface

// File: rtl/tfe_flow_state_table.sv
// Per-flow state table: pipelined read-modify-write of {pkt_cnt, last_time, valid} per hash index,
// idle-timeout detection, and a drain-then-sweep full-table clear.
module tfe_flow_state_table #(
  parameter int unsigned       ADDR_W  = 16,
  parameter int unsigned       CNT_W   = 5,
  parameter int unsigned       TIME_W  = 34,
  parameter logic [TIME_W-1:0] TIMEOUT = TIME_W'(1000000)
) (
  input logic                   clk,
  input logic                   rst,
  tfe_flow_state_table_if.slave bus
);
  localparam int unsigned ENT_W = CNT_W + TIME_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWEEP} state_t;

  state_t            state, state_nxt;
  logic              ready_d, busy_d, sweep_en_c, sweep_enter_c;
  logic [ADDR_W-1:0] sweep_addr;
  logic              accept_c;

  logic              s1_v, s2_v;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  logic [TIME_W-1:0] s1_time, s2_time;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  rd_q1, rd_q2;

  logic              wb1_v, wb2_v;
  logic [ADDR_W-1:0] wb1_addr, wb2_addr;
  logic [ENT_W-1:0]  wb1_data, wb2_data;

  logic [ENT_W-1:0]  prior_c, upd_c, wr_data_c;
  logic              prior_valid_c, fresh_c, wr_en_c;
  logic [CNT_W-1:0]  prior_cnt_c, new_cnt_c;
  logic [TIME_W-1:0] prior_time_c, delta_c;
  logic [ADDR_W-1:0] wr_addr_c;

  assign accept_c = bus.req_valid & bus.req_ready;

  // Clear FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Clear FSM next state: wait for the two in-flight stages to empty, then sweep every index
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.clear_start) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_v && !s2_v) state_nxt = ST_SWEEP;
      ST_SWEEP: if (sweep_addr == '1) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Clear FSM outputs; ready/busy are computed from the next state so they flop in step with it
  always_comb begin
    ready_d       = 1'b0;
    busy_d        = 1'b1;
    sweep_en_c    = (state == ST_SWEEP);
    sweep_enter_c = (state != ST_SWEEP) && (state_nxt == ST_SWEEP);
    if (state_nxt == ST_IDLE) begin
      ready_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  // Registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.req_ready  <= 1'b1;
      bus.clear_busy <= 1'b0;
    end else begin
      bus.req_ready  <= ready_d;
      bus.clear_busy <= busy_d;
    end
  end

  // Sweep address walks the whole table while sweeping, parks at zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sweep_addr <= '0;
    else if (sweep_en_c) sweep_addr <= sweep_addr + ADDR_W'(1);
    else                 sweep_addr <= '0;
  end

  // Request pipeline: stage 1 waits on the RAM, stage 2 meets the read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_addr <= '0;
      s2_addr <= '0;
      s1_time <= '0;
      s2_time <= '0;
    end else begin
      s1_v    <= accept_c;
      s1_addr <= bus.req_addr;
      s1_time <= bus.req_time;
      s2_v    <= s1_v;
      s2_addr <= s1_addr;
      s2_time <= s1_time;
    end
  end

  // Table RAM: one write, one read with two register stages; a same-edge read returns old data
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= wr_data_c;
    rd_q1 <= mem[bus.req_addr];
    rd_q2 <= rd_q1;
  end

  // Entry update: newest writeback wins over RAM, then timeout test and saturating count
  always_comb begin
    prior_c = rd_q2;
    if (wb1_v && (wb1_addr == s2_addr))      prior_c = wb1_data;
    else if (wb2_v && (wb2_addr == s2_addr)) prior_c = wb2_data;
    prior_valid_c = prior_c[0];
    prior_time_c  = prior_c[TIME_W:1];
    prior_cnt_c   = prior_c[ENT_W-1:TIME_W+1];
    delta_c       = s2_time - prior_time_c;
    fresh_c       = !prior_valid_c || (delta_c >= TIMEOUT);
    if (fresh_c)                 new_cnt_c = CNT_W'(1);
    else if (prior_cnt_c == '1)  new_cnt_c = prior_cnt_c;
    else                         new_cnt_c = prior_cnt_c + CNT_W'(1);
    upd_c     = {new_cnt_c, s2_time, 1'b1};
    wr_en_c   = s2_v || sweep_en_c;
    wr_addr_c = sweep_en_c ? sweep_addr : s2_addr;
    wr_data_c = sweep_en_c ? '0 : upd_c;
  end

  // Writebacks from the last two cycles, not yet visible to a read launched two cycles ago
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb1_v    <= 1'b0;
      wb2_v    <= 1'b0;
      wb1_addr <= '0;
      wb2_addr <= '0;
      wb1_data <= '0;
      wb2_data <= '0;
    end else if (sweep_enter_c) begin
      wb1_v <= 1'b0;
      wb2_v <= 1'b0;
    end else begin
      wb1_v    <= s2_v;
      wb1_addr <= s2_addr;
      wb1_data <= upd_c;
      wb2_v    <= wb1_v;
      wb2_addr <= wb1_addr;
      wb2_data <= wb1_data;
    end
  end

  // Registered response, one strobe per completed lookup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid    <= 1'b0;
      bus.rsp_addr     <= '0;
      bus.rsp_pkt_cnt  <= '0;
      bus.rsp_new      <= 1'b0;
      bus.rsp_expired  <= 1'b0;
      bus.rsp_old_cnt  <= '0;
      bus.rsp_old_time <= '0;
    end else begin
      bus.rsp_valid <= s2_v;
      if (s2_v) begin
        bus.rsp_addr     <= s2_addr;
        bus.rsp_pkt_cnt  <= new_cnt_c;
        bus.rsp_new      <= fresh_c;
        bus.rsp_expired  <= prior_valid_c && fresh_c;
        bus.rsp_old_cnt  <= (prior_valid_c && fresh_c) ? prior_cnt_c : '0;
        bus.rsp_old_time <= prior_valid_c ? prior_time_c : '0;
      end
    end
  end
endmodule
